if_inst_queue: RTL and testbench

//  Parametrised instruction-fetch queue; successor to the single-entry IF buffer/cancel flag.

---
 rtl/if_queue_pkg.sv | 26 ++
 rtl/if_inst_queue_if.sv | 36 +++
 rtl/if_inst_queue_chk.sv | 23 ++
 rtl/if_queue_cancel_ctr.sv | 60 ++++++
 rtl/if_inst_queue.sv | 167 ++++++++++++++++
 tb/tb_if_inst_queue.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/if_queue_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
// Contents:
//   IQ_DEPTH / IQ_PC_W / IQ_INST_W  default geometry of the queue
//   IQ_PTR_W / IQ_CNT_W             index and wrap-bit pointer widths for IQ_DEPTH
//   entry_t                         one queue slot {pc, inst, filled}
//   merge_flush()                   folds both flush sources into one kill
package if_queue_pkg;

    localparam int IQ_DEPTH  = 4;
    localparam int IQ_PC_W   = 32;
    localparam int IQ_INST_W = 32;
    localparam int IQ_PTR_W  = $clog2(IQ_DEPTH);
    localparam int IQ_CNT_W  = IQ_PTR_W + 1;

    typedef struct packed {
        logic [IQ_PC_W-1:0]   pc;
        logic [IQ_INST_W-1:0] inst;
        logic                 filled;
    } entry_t;

    // Exception/ertn and branch-mispredict flushes have identical effect.
    function automatic logic merge_flush(input logic excep_flush, input logic branch_flush);
        return excep_flush | branch_flush;
    endfunction

endpackage

// File: rtl/if_inst_queue_if.sv
// Fetch-path bundle between pre-IF / memory response / ID and the fetch queue.
// master: the surrounding pipeline (drives requests, responses, flushes, ID allowin).
// slave : the queue (drives now_allowin_o and the two decode slots).
interface if_inst_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              pre_req_fire_i;
    logic [PC_W-1:0]   pre_pc_i;
    logic              now_allowin_o;
    logic              inst_data_ok_i;
    logic [INST_W-1:0] inst_rdata_i;
    logic              excep_flush_i;
    logic              branch_flush_i;
    logic              next_allowin_i;
    logic              line1_valid_o;
    logic [PC_W-1:0]   line1_pc_o;
    logic [INST_W-1:0] line1_inst_o;
    logic              line2_valid_o;
    logic [PC_W-1:0]   line2_pc_o;
    logic [INST_W-1:0] line2_inst_o;

    modport master (
        output pre_req_fire_i, pre_pc_i, inst_data_ok_i, inst_rdata_i,
               excep_flush_i, branch_flush_i, next_allowin_i,
        input  now_allowin_o, line1_valid_o, line1_pc_o, line1_inst_o,
               line2_valid_o, line2_pc_o, line2_inst_o
    );

    modport slave (
        input  pre_req_fire_i, pre_pc_i, inst_data_ok_i, inst_rdata_i,
               excep_flush_i, branch_flush_i, next_allowin_i,
        output now_allowin_o, line1_valid_o, line1_pc_o, line1_inst_o,
               line2_valid_o, line2_pc_o, line2_inst_o
    );
endinterface

// File: rtl/if_inst_queue_chk.sv
// Protocol checks for the fetch queue (simulation only).
// Ports: clk, rst, fire_i, full_i, data_ok_i, discard_i, pend_i.
module if_inst_queue_chk import if_queue_pkg::*; #(
    parameter int CNT_W = IQ_CNT_W
) (
    input logic             clk,
    input logic             rst,
    input logic             fire_i,
    input logic             full_i,
    input logic             data_ok_i,
    input logic             discard_i,
    input logic [CNT_W-1:0] pend_i
);

    a_no_fire_when_full: assert property (@(posedge clk) disable iff (rst)
        !(fire_i && full_i))
        else $error("request accepted while queue full");

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(data_ok_i && !discard_i && (pend_i == {CNT_W{1'b0}})))
        else $error("response with no outstanding request");

endmodule

// File: rtl/if_queue_cancel_ctr.sv
// Counts fetch responses still owed to requests killed by a flush.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   data_ok_i    a response arrives this cycle
//   fire_i       a request is accepted this cycle
//   flush_i      merged flush
//   pend_i       requests allocated in the queue but not yet filled
//   discard_o    this cycle's response belongs to a cancelled request
//   fill_o       this cycle's response fills the queue
module if_queue_cancel_ctr import if_queue_pkg::*; #(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ok_i,
    input  logic             fire_i,
    input  logic             flush_i,
    input  logic [CNT_W-1:0] pend_i,
    output logic             discard_o,
    output logic             fill_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sum_s;

    // Discard/fill decision and next cancel count.
    always_comb begin
        discard_o = data_ok_i && (cnt_q != CNT_ZERO);
        fill_o    = data_ok_i && (cnt_q == CNT_ZERO) && (pend_i != CNT_ZERO);
        // On flush every unreturned request plus this cycle's fire becomes owed;
        // a response consumed this cycle (either way) is no longer owed.
        sum_s = {1'b0, cnt_q} - {{CNT_W{1'b0}}, discard_o}
              + {1'b0, pend_i} + {{CNT_W{1'b0}}, fire_i}
              - {{CNT_W{1'b0}}, fill_o};
        if (flush_i) begin
            if (sum_s > CNT_LIMIT) begin
                cnt_d = CNT_LIMIT[CNT_W-1:0];
            end else begin
                cnt_d = sum_s[CNT_W-1:0];
            end
        end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, discard_o};
        end
    end

    // Cancel count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/if_inst_queue.sv
// Instruction-fetch queue between pre-IF and dual-issue ID.
// One entry is allocated per accepted request, filled in order by responses,
// and up to two filled entries are offered to ID per cycle. A flush empties the
// queue and hands all unreturned responses to the cancel counter.
// Ports: clk, rst (asynchronous, active-high), bus (if_inst_queue_if.slave).
// Option: define IF_QUEUE_BYPASS_EN to forward a response that fills the oldest
// entry straight onto line1 in the same cycle.
module if_inst_queue import if_queue_pkg::*; #(
    parameter  int DEPTH  = IQ_DEPTH,
    parameter  int PC_W   = IQ_PC_W,
    parameter  int INST_W = IQ_INST_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input logic            clk,
    input logic            rst,
    if_inst_queue_if.slave bus
);

`ifdef IF_QUEUE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2'd2);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam entry_t           ENTRY_ZERO = entry_t'({$bits(entry_t){1'b0}});

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [CNT_W-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
    logic [CNT_W-1:0] occ_s, pend_s, pop_cnt_s;
    logic [PTR_W-1:0] alloc_idx_s, fill_idx_s, rd_idx_s, rd1_idx_s;
    logic             flush_s, full_s, discard_s, fill_en_s, byp_s;
    logic             l1_base_s, l2_base_s, l1_valid_s, l2_valid_s, pop_s;
    logic [PC_W-1:0]  l1_pc_s, l2_pc_s;
    logic [INST_W-1:0] l1_inst_s, l2_inst_s;

    if_queue_cancel_ctr #(.DEPTH(DEPTH)) u_cancel (
        .clk       (clk),
        .rst       (rst),
        .data_ok_i (bus.inst_data_ok_i),
        .fire_i    (bus.pre_req_fire_i),
        .flush_i   (flush_s),
        .pend_i    (pend_s),
        .discard_o (discard_s),
        .fill_o    (fill_en_s)
    );

    if_inst_queue_chk #(.CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .fire_i    (bus.pre_req_fire_i),
        .full_i    (full_s),
        .data_ok_i (bus.inst_data_ok_i),
        .discard_i (discard_s),
        .pend_i    (pend_s)
    );

    // Occupancy, slot selection and the two ID-facing lines.
    always_comb begin
        flush_s     = merge_flush(bus.excep_flush_i, bus.branch_flush_i);
        occ_s       = alloc_q - rd_q;
        pend_s      = alloc_q - fill_q;
        full_s      = (occ_s == CNT_DEPTH);
        alloc_idx_s = alloc_q[PTR_W-1:0];
        fill_idx_s  = fill_q[PTR_W-1:0];
        rd_idx_s    = rd_q[PTR_W-1:0];
        rd1_idx_s   = rd_idx_s + PTR_W'(1'b1);
        // Bypass only when the response lands in the oldest entry (fill == rd).
        byp_s       = BYPASS_EN && fill_en_s && (fill_q == rd_q) && !flush_s;
        l1_base_s   = (occ_s != CNT_ZERO) && entry_q[rd_idx_s].filled;
        l2_base_s   = (occ_s >= CNT_TWO) && entry_q[rd1_idx_s].filled && l1_base_s;
        l1_valid_s  = !flush_s && (l1_base_s || byp_s);
        l2_valid_s  = !flush_s && l2_base_s;
        l1_pc_s     = {PC_W{1'b0}};
        l1_inst_s   = {INST_W{1'b0}};
        l2_pc_s     = {PC_W{1'b0}};
        l2_inst_s   = {INST_W{1'b0}};
        if (l1_valid_s) begin
            l1_pc_s   = entry_q[rd_idx_s].pc;
            l1_inst_s = l1_base_s ? entry_q[rd_idx_s].inst : bus.inst_rdata_i;
        end else begin
            l1_pc_s   = {PC_W{1'b0}};
        end
        if (l2_valid_s) begin
            l2_pc_s   = entry_q[rd1_idx_s].pc;
            l2_inst_s = entry_q[rd1_idx_s].inst;
        end else begin
            l2_pc_s   = {PC_W{1'b0}};
        end
        pop_s     = bus.next_allowin_i && !flush_s;
        pop_cnt_s = pop_s ? ({{(CNT_W-1){1'b0}}, l1_valid_s} + {{(CNT_W-1){1'b0}}, l2_valid_s})
                          : CNT_ZERO;
        bus.now_allowin_o = !full_s;
        bus.line1_valid_o = l1_valid_s;
        bus.line1_pc_o    = l1_pc_s;
        bus.line1_inst_o  = l1_inst_s;
        bus.line2_valid_o = l2_valid_s;
        bus.line2_pc_o    = l2_pc_s;
        bus.line2_inst_o  = l2_inst_s;
    end

    // Next entry array and pointers.
    always_comb begin
        entry_d = entry_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        if (flush_s) begin
            alloc_d = CNT_ZERO;
            fill_d  = CNT_ZERO;
            rd_d    = CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].filled = 1'b0;
            end
        end else begin
            if (bus.pre_req_fire_i) begin
                entry_d[alloc_idx_s].pc     = bus.pre_pc_i;
                entry_d[alloc_idx_s].filled = 1'b0;
                alloc_d = alloc_q + CNT_ONE;
            end else begin
                alloc_d = alloc_q;
            end
            if (fill_en_s) begin
                entry_d[fill_idx_s].inst   = bus.inst_rdata_i;
                entry_d[fill_idx_s].filled = 1'b1;
                fill_d = fill_q + CNT_ONE;
            end else begin
                fill_d = fill_q;
            end
            // Clearing after the fill means a bypassed entry popped this cycle never stays filled.
            if (pop_s && l1_valid_s) begin
                entry_d[rd_idx_s].filled = 1'b0;
            end else begin
                rd_d = rd_q;
            end
            if (pop_s && l2_valid_s) begin
                entry_d[rd1_idx_s].filled = 1'b0;
            end else begin
                rd_d = rd_q;
            end
            rd_d = rd_q + pop_cnt_s;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q <= CNT_ZERO;
            fill_q  <= CNT_ZERO;
            rd_q    <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= ENTRY_ZERO;
            end
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed, table-driven bench for if_inst_queue (default build, no bypass).
module tb_if_inst_queue;

    logic clk;
    logic rst;
    int   checks_total;
    int   checks_pass;

    if_inst_queue_if #(.PC_W(32), .INST_W(32)) bus ();

    if_inst_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fire;
        logic [31:0] pc;
        logic        dok;
        logic [31:0] rdata;
        logic        exf;
        logic        brf;
        logic        nal;
        logic        e_allow;
        logic        e_v1;
        logic [31:0] e_pc1;
        logic [31:0] e_in1;
        logic        e_v2;
        logic [31:0] e_pc2;
        logic [31:0] e_in2;
        int          e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic r(input logic fire, input logic [31:0] pc, input logic dok,
                     input logic [31:0] rdata, input logic exf, input logic brf,
                     input logic nal, input logic al, input logic v1,
                     input logic [31:0] p1, input logic [31:0] i1, input logic v2,
                     input logic [31:0] p2, input logic [31:0] i2, input int cnt);
        vec_t v;
        v.fire = fire; v.pc = pc; v.dok = dok; v.rdata = rdata;
        v.exf = exf; v.brf = brf; v.nal = nal; v.e_allow = al;
        v.e_v1 = v1; v.e_pc1 = p1; v.e_in1 = i1;
        v.e_v2 = v2; v.e_pc2 = p2; v.e_in2 = i2; v.e_cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic fire, input logic [31:0] pc, input logic dok,
                         input logic [31:0] rdata, input logic exf, input logic brf,
                         input logic nal);
        bus.pre_req_fire_i = fire;
        bus.pre_pc_i       = pc;
        bus.inst_data_ok_i = dok;
        bus.inst_rdata_i   = rdata;
        bus.excep_flush_i  = exf;
        bus.branch_flush_i = brf;
        bus.next_allowin_i = nal;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total = 0;
        checks_pass  = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // ---- reset state ----
        @(negedge clk);
        chk("rst allow", {31'b0, bus.now_allowin_o}, 32'd1);
        chk("rst v1",    {31'b0, bus.line1_valid_o}, 32'd0);
        chk("rst v2",    {31'b0, bus.line2_valid_o}, 32'd0);
        chk("rst pc1",   bus.line1_pc_o,   32'h0);
        chk("rst inst1", bus.line1_inst_o, 32'h0);
        chk("rst pc2",   bus.line2_pc_o,   32'h0);
        chk("rst inst2", bus.line2_inst_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fire dok dat exf brf nal | allow v1 pc1 in1 v2 pc2 in2 cnt
        // single fetch, latency 1
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        r(1, 32'h1c000000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800000, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h1c000000, 32'h02800000, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000000, 32'h02800000, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        // fill to full, then dual pops
        r(1, 32'h1c000010, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000014, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000018, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c00001c, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800010, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800014, 0, 0, 0,  0, 1, 32'h1c000010, 32'h02800010, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800018, 0, 0, 0,  0, 1, 32'h1c000010, 32'h02800010, 1, 32'h1c000014, 32'h02800014, -1);
        r(0, 0, 1, 32'h0280001c, 0, 0, 0,  0, 1, 32'h1c000010, 32'h02800010, 1, 32'h1c000014, 32'h02800014, -1);
        r(0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h1c000010, 32'h02800010, 1, 32'h1c000014, 32'h02800014, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000018, 32'h02800018, 1, 32'h1c00001c, 32'h0280001c, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        // 3 outstanding + branch flush with same-cycle fire -> 4 cancelled
        r(1, 32'h1c000020, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000024, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000028, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c00002c, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0);
        r(0, 0, 1, 32'hdead0001, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 4);
        r(0, 0, 1, 32'hdead0002, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 3);
        r(1, 32'h1c000100, 1, 32'hdead0003, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 2);
        r(0, 0, 1, 32'hdead0004, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1);
        r(0, 0, 1, 32'h02800100, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        r(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h1c000100, 32'h02800100, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000100, 32'h02800100, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        // exception flush with data_ok while pend=2 -> one response still owed
        r(1, 32'h1c000200, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000204, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000208, 1, 32'h02800200, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h1c000200, 32'h02800200, 0, 0, 0, 0);
        r(0, 0, 1, 32'h11111111, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
        r(0, 0, 1, 32'h22222222, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        r(1, 32'h1c000300, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800300, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000300, 32'h02800300, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        // line2 unfilled with allowin toggling: rd advances by one
        r(1, 32'h1c000400, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(1, 32'h1c000404, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800400, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000400, 32'h02800400, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 1, 32'h02800404, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 1, 32'h1c000404, 32'h02800404, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 1,  1, 1, 32'h1c000404, 32'h02800404, 0, 0, 0, -1);
        r(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, -1);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].fire, vq[k].pc, vq[k].dok, vq[k].rdata,
                  vq[k].exf, vq[k].brf, vq[k].nal);
            @(negedge clk);
            chk($sformatf("r%0d allow", k), {31'b0, bus.now_allowin_o}, {31'b0, vq[k].e_allow});
            chk($sformatf("r%0d v1", k), {31'b0, bus.line1_valid_o}, {31'b0, vq[k].e_v1});
            if (vq[k].e_v1) begin
                chk($sformatf("r%0d pc1", k), bus.line1_pc_o, vq[k].e_pc1);
                chk($sformatf("r%0d inst1", k), bus.line1_inst_o, vq[k].e_in1);
            end
            chk($sformatf("r%0d v2", k), {31'b0, bus.line2_valid_o}, {31'b0, vq[k].e_v2});
            if (vq[k].e_v2) begin
                chk($sformatf("r%0d pc2", k), bus.line2_pc_o, vq[k].e_pc2);
                chk($sformatf("r%0d inst2", k), bus.line2_inst_o, vq[k].e_in2);
            end
            if (vq[k].e_cnt >= 0) begin
                chk($sformatf("r%0d cancel_cnt", k), {29'b0, dut.u_cancel.cnt_q}, 32'(vq[k].e_cnt));
            end
            idle_cycle();
        end

        // ---- pointer wrap: overlapped fire / data_ok / pop, one out per cycle ----
        for (int k = 0; k < 12; k++) begin
            drive((k < 10), 32'h1c001000 + 32'(4 * k),
                  (k >= 1 && k <= 10), 32'h03000000 + 32'(k - 1), 0, 0, 1);
            @(negedge clk);
            chk($sformatf("wrap%0d allow", k), {31'b0, bus.now_allowin_o}, 32'd1);
            chk($sformatf("wrap%0d v1", k), {31'b0, bus.line1_valid_o}, {31'b0, (k >= 2)});
            if (k >= 2) begin
                chk($sformatf("wrap%0d pc1", k), bus.line1_pc_o, 32'h1c001000 + 32'(4 * (k - 2)));
                chk($sformatf("wrap%0d inst1", k), bus.line1_inst_o, 32'h03000000 + 32'(k - 2));
            end
            chk($sformatf("wrap%0d v2", k), {31'b0, bus.line2_valid_o}, 32'd0);
            idle_cycle();
        end

        // ---- reset in the middle of operation ----
        drive(1, 32'h1c009000, 0, 0, 0, 0, 0);
        idle_cycle();
        drive(1, 32'h1c009004, 1, 32'h02809000, 0, 0, 0);
        idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid v1 before rst", {31'b0, bus.line1_valid_o}, 32'd1);
        chk("mid pc1 before rst", bus.line1_pc_o, 32'h1c009000);
        rst = 1'b1;
        #1;
        chk("mid rst v1", {31'b0, bus.line1_valid_o}, 32'd0);
        chk("mid rst allow", {31'b0, bus.now_allowin_o}, 32'd1);
        chk("mid rst pc1", bus.line1_pc_o, 32'h0);
        chk("mid rst cancel_cnt", {29'b0, dut.u_cancel.cnt_q}, 32'd0);
        idle_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post rst v1", {31'b0, bus.line1_valid_o}, 32'd0);
        chk("post rst v2", {31'b0, bus.line2_valid_o}, 32'd0);
        idle_cycle();

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
